// File: rtl/motor_step_pkg.sv
// -----------------------------------------------------------------------------
// motor_step_pkg
// Shared definitions for the multi-motor step sequencer:
//   - step_state_e  : engine FSM state encoding (IDLE, CHECK, DELAY, DONE)
//   - INC_HALF/FULL : position increment per step, in half-step units
//   - PHASE_RESET   : winding drive for position index 0
//   - phase_lookup  : 8-entry half-step winding table (bits A,B,A',B', MSB first)
// -----------------------------------------------------------------------------
package motor_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DELAY = 2'd2,
        ST_DONE  = 2'd3
    } step_state_e;

    localparam logic [1:0] INC_HALF    = 2'd1;
    localparam logic [1:0] INC_FULL    = 2'd2;
    localparam logic [3:0] PHASE_RESET = 4'b1000;

    // Half-step sequence: even indices energise one coil, odd indices two.
    function automatic logic [3:0] phase_lookup(input logic [2:0] idx);
        logic [3:0] drive;
        case (idx)
            3'd0:    drive = 4'b1000;
            3'd1:    drive = 4'b1100;
            3'd2:    drive = 4'b0100;
            3'd3:    drive = 4'b0110;
            3'd4:    drive = 4'b0010;
            3'd5:    drive = 4'b0011;
            3'd6:    drive = 4'b0001;
            3'd7:    drive = 4'b1001;
            default: drive = PHASE_RESET;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/motor_step_engine_if.sv
// -----------------------------------------------------------------------------
// motor_step_engine_if
// Move-command handshake between the control FSM (master) and the step
// engine (slave).
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  engine idle and able to accept
//   cmd_motor  master->slave  target motor index
//   cmd_steps  master->slave  signed step count (sign = direction)
//   cmd_half   master->slave  1 = half-step, 0 = full-step
//   cmd_delay  master->slave  inter-step delay in clk cycles (0 acts as 1)
// -----------------------------------------------------------------------------
interface motor_step_engine_if #(
    parameter int MOTOR_W = 1,
    parameter int STEP_W  = 8,
    parameter int DELAY_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [MOTOR_W-1:0] cmd_motor;
    logic [STEP_W-1:0]  cmd_steps;
    logic               cmd_half;
    logic [DELAY_W-1:0] cmd_delay;

    modport master (
        output cmd_valid, cmd_motor, cmd_steps, cmd_half, cmd_delay,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_motor, cmd_steps, cmd_half, cmd_delay,
        output cmd_ready
    );
endinterface

// File: rtl/step_delay_counter.sv
// -----------------------------------------------------------------------------
// step_delay_counter
// Down-counter timing the DELAY phase of each step.
//   clk, reset_n  clock, asynchronous active-low reset
//   load          load load_value (0 is loaded as 1)
//   load_value    delay in cycles
//   enable        count down one per cycle
//   expired       registered; high while the count is 1, i.e. during the
//                 last delay cycle
// -----------------------------------------------------------------------------
module step_delay_counter #(
    parameter int DELAY_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_value,
    input  logic               enable,
    output logic               expired
);
    logic [DELAY_W-1:0] count_r;
    logic [DELAY_W-1:0] count_next_s;
    logic               expired_r;
    logic               expired_next_s;

    // Next count and look-ahead expiry flag so expired is a flop output.
    always_comb begin
        count_next_s   = count_r;
        expired_next_s = expired_r;
        if (load) begin
            if (load_value == {DELAY_W{1'b0}}) begin
                count_next_s = {{(DELAY_W-1){1'b0}}, 1'b1};
            end else begin
                count_next_s = load_value;
            end
            expired_next_s = (count_next_s == {{(DELAY_W-1){1'b0}}, 1'b1});
        end else if (enable) begin
            if (count_r != {DELAY_W{1'b0}}) begin
                count_next_s = count_r - {{(DELAY_W-1){1'b0}}, 1'b1};
            end else begin
                count_next_s = count_r;
            end
            expired_next_s = (count_next_s == {{(DELAY_W-1){1'b0}}, 1'b1});
        end else begin
            count_next_s   = count_r;
            expired_next_s = expired_r;
        end
    end

    // Count and expiry registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r   <= {DELAY_W{1'b0}};
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            expired_r <= expired_next_s;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/motor_step_engine.sv
// -----------------------------------------------------------------------------
// motor_step_engine
// Multi-motor step sequencer. Accepts one move command at a time, steps the
// selected motor's position once per (1 + delay) cycles and drives four
// winding-phase outputs per motor from the half-step table.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   cmd           motor_step_engine_if.slave command handshake
//   abort         stop current move (only with MOTOR_STEP_ABORT_EN)
//   busy          engine not idle
//   done          one-cycle pulse on move completion
//   aborted       qualifies done: move ended by abort
//   position      NUM_MOTORS*POS_W flattened positions, motor 0 in LSBs
//   phase         NUM_MOTORS*4 flattened winding drive, motor 0 in LSBs
//
// Build option: define MOTOR_STEP_ABORT_EN to honour abort in CHECK/DELAY.
// Without it, abort is ignored and aborted stays 0.
// -----------------------------------------------------------------------------
module motor_step_engine
    import motor_step_pkg::*;
#(
    parameter int NUM_MOTORS = 2,
    parameter int MOTOR_W    = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1,
    parameter int STEP_W     = 8,
    parameter int DELAY_W    = 16,
    parameter int POS_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    motor_step_engine_if.slave          cmd,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [NUM_MOTORS*POS_W-1:0] position,
    output logic [NUM_MOTORS*4-1:0]     phase
);
    localparam logic [MOTOR_W:0] NUM_MOTORS_C = (MOTOR_W+1)'(NUM_MOTORS);

    step_state_e                         state_r;
    step_state_e                         state_next_s;

    logic [MOTOR_W-1:0]                  motor_r;
    logic                                dir_neg_r;
    logic [STEP_W-1:0]                   remaining_r;
    logic [1:0]                          inc_r;
    logic [DELAY_W-1:0]                  delay_r;

    logic [NUM_MOTORS-1:0][POS_W-1:0]    pos_r;
    logic [NUM_MOTORS-1:0][POS_W-1:0]    pos_next_s;
    logic [NUM_MOTORS-1:0][3:0]          phase_r;

    logic                                busy_r;
    logic                                done_r;
    logic                                aborted_r;
    logic                                cmd_ready_r;

    logic                                accept_s;
    logic                                step_s;
    logic                                load_s;
    logic                                count_en_s;
    logic                                abort_done_s;
    logic                                abort_s;
    logic                                expired_s;
    logic                                motor_valid_s;
    logic [STEP_W-1:0]                   mag_s;
    logic [POS_W-1:0]                    inc_ext_s;

`ifdef MOTOR_STEP_ABORT_EN
    assign abort_s = abort;
`else
    logic unused_abort_s;
    assign unused_abort_s = abort;
    assign abort_s        = 1'b0;
`endif

    // Out-of-range motors are accepted but treated as a 0-step move.
    assign motor_valid_s = ({1'b0, cmd.cmd_motor} < NUM_MOTORS_C);
    // Unsigned magnitude; the most negative count maps to 2^(STEP_W-1).
    assign mag_s = cmd.cmd_steps[STEP_W-1] ? (~cmd.cmd_steps + STEP_W'(1))
                                           : cmd.cmd_steps;
    assign inc_ext_s = {{(POS_W-2){1'b0}}, inc_r};

    step_delay_counter #(
        .DELAY_W    (DELAY_W)
    ) u_delay (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_s),
        .load_value (delay_r),
        .enable     (count_en_s),
        .expired    (expired_s)
    );

    // FSM next-state and step control.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        load_s       = 1'b0;
        count_en_s   = 1'b0;
        abort_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (abort_s) begin
                    abort_done_s = 1'b1;
                    state_next_s = ST_DONE;
                end else if (remaining_r == {STEP_W{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    step_s       = 1'b1;
                    load_s       = 1'b1;
                    state_next_s = ST_DELAY;
                end
            end
            ST_DELAY: begin
                count_en_s = 1'b1;
                if (abort_s) begin
                    abort_done_s = 1'b1;
                    state_next_s = ST_DONE;
                end else if (expired_s) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_DELAY;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch on accept; remaining count decrements on each step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            motor_r     <= {MOTOR_W{1'b0}};
            dir_neg_r   <= 1'b0;
            remaining_r <= {STEP_W{1'b0}};
            inc_r       <= INC_HALF;
            delay_r     <= {{(DELAY_W-1){1'b0}}, 1'b1};
        end else if (accept_s) begin
            motor_r     <= cmd.cmd_motor;
            dir_neg_r   <= cmd.cmd_steps[STEP_W-1];
            remaining_r <= motor_valid_s ? mag_s : {STEP_W{1'b0}};
            inc_r       <= cmd.cmd_half ? INC_HALF : INC_FULL;
            delay_r     <= (cmd.cmd_delay == {DELAY_W{1'b0}})
                           ? {{(DELAY_W-1){1'b0}}, 1'b1} : cmd.cmd_delay;
        end else if (step_s) begin
            remaining_r <= remaining_r - STEP_W'(1);
        end else begin
            remaining_r <= remaining_r;
        end
    end

    // Next position per motor: only the selected motor moves, modulo 2^POS_W.
    always_comb begin
        pos_next_s = pos_r;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (step_s && (motor_r == MOTOR_W'(i))) begin
                if (dir_neg_r) begin
                    pos_next_s[i] = pos_r[i] - inc_ext_s;
                end else begin
                    pos_next_s[i] = pos_r[i] + inc_ext_s;
                end
            end else begin
                pos_next_s[i] = pos_r[i];
            end
        end
    end

    // Positions and phase drive update together so both change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_r   <= {(NUM_MOTORS*POS_W){1'b0}};
            phase_r <= {NUM_MOTORS{PHASE_RESET}};
        end else begin
            pos_r <= pos_next_s;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                phase_r[i] <= phase_lookup(pos_next_s[i][2:0]);
            end
        end
    end

    // Status outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= (state_next_s == ST_DONE);
            aborted_r   <= abort_done_s;
            cmd_ready_r <= (state_next_s == ST_IDLE);
        end
    end

    assign cmd.cmd_ready = cmd_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign aborted       = aborted_r;
    assign position      = pos_r;
    assign phase         = phase_r;

endmodule

// File: tb/tb_motor_step_engine.sv
// -----------------------------------------------------------------------------
// tb_motor_step_engine
// Directed bench for motor_step_engine with three motors (so that motor
// index 3 is out of range). Offsets are counted in cycles after the accept
// edge: offset 1 is the first CHECK cycle.
// -----------------------------------------------------------------------------
module tb_motor_step_engine;
    localparam int NUM_MOTORS = 3;
    localparam int MOTOR_W    = 2;
    localparam int STEP_W     = 8;
    localparam int DELAY_W    = 16;
    localparam int POS_W      = 8;

`ifdef MOTOR_STEP_ABORT_EN
    localparam logic [7:0] M0_AFTER_ABORT = 8'd6;
    localparam logic [3:0] PH0_AFTER      = 4'b0001;
`else
    localparam logic [7:0] M0_AFTER_ABORT = 8'd13;
    localparam logic [3:0] PH0_AFTER      = 4'b0011;
`endif

    logic                        clk;
    logic                        reset_n;
    logic                        abort;
    logic                        busy;
    logic                        done;
    logic                        aborted;
    logic [NUM_MOTORS*POS_W-1:0] position;
    logic [NUM_MOTORS*4-1:0]     phase;

    int vectors;
    int miscompares;

    motor_step_engine_if #(
        .MOTOR_W (MOTOR_W),
        .STEP_W  (STEP_W),
        .DELAY_W (DELAY_W)
    ) cmd_if ();

    motor_step_engine #(
        .NUM_MOTORS (NUM_MOTORS),
        .MOTOR_W    (MOTOR_W),
        .STEP_W     (STEP_W),
        .DELAY_W    (DELAY_W),
        .POS_W      (POS_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd      (cmd_if),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .position (position),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance from offset start_off until done rises; check the offset it rose at.
    task automatic wait_done(input string tag, input int start_off, input int exp_off);
        int off;
        off = start_off;
        while (done !== 1'b1 && off < exp_off + 16) begin
            tick();
            off++;
        end
        chk(tag, off, exp_off);
    endtask

    task automatic offer(input logic [1:0] m, input logic [7:0] s, input logic h,
                         input logic [15:0] d);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_motor = m;
        cmd_if.cmd_steps = s;
        cmd_if.cmd_half  = h;
        cmd_if.cmd_delay = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        abort       = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_motor = 2'd0;
        cmd_if.cmd_steps = 8'd0;
        cmd_if.cmd_half  = 1'b0;
        cmd_if.cmd_delay = 16'd0;
        ticks(3);
        reset_n = 1'b1;
        ticks(2);

        // Reset state
        chk("rst_pos",   position, 24'h000000);
        chk("rst_phase", phase,    12'h888);
        chk("rst_ready", cmd_if.cmd_ready, 1'b1);
        chk("rst_busy",  busy,    1'b0);
        chk("rst_done",  done,    1'b0);
        chk("rst_abrt",  aborted, 1'b0);

        // Motor 0, +3 half-steps, delay 2: period 3, done at offset 11
        offer(2'd0, 8'sd3, 1'b1, 16'd2);
        tick();
        cmd_if.cmd_valid = 1'b0;
        chk("m0_chk_busy",  busy, 1'b1);
        chk("m0_chk_ready", cmd_if.cmd_ready, 1'b0);
        chk("m0_chk_pos",   position, 24'h000000);
        tick();
        chk("m0_pos1", position, 24'h000001);
        chk("m0_ph1",  phase,    12'h88C);
        ticks(3);
        chk("m0_pos2", position, 24'h000002);
        chk("m0_ph2",  phase,    12'h884);
        ticks(3);
        chk("m0_pos3", position, 24'h000003);
        chk("m0_ph3",  phase,    12'h886);
        ticks(2);
        chk("m0_nodone10", done, 1'b0);
        tick();
        chk("m0_done11", done,    1'b1);
        chk("m0_abrt11", aborted, 1'b0);
        tick();
        chk("m0_done_pulse", done, 1'b0);
        chk("m0_ready12",    cmd_if.cmd_ready, 1'b1);
        chk("m0_busy12",     busy, 1'b0);

        // Motor 1, -2 full-steps, delay 0 (acts as 1): wraps 0 -> 254 -> 252
        offer(2'd1, 8'hFE, 1'b0, 16'd0);
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("m1_pos1", position, 24'h00FE03);
        chk("m1_ph1",  phase,    12'h816);
        ticks(2);
        chk("m1_pos2", position, 24'h00FC03);
        chk("m1_ph2",  phase,    12'h826);
        tick();
        chk("m1_nodone5", done, 1'b0);
        tick();
        chk("m1_done6", done, 1'b1);
        tick();

        // Zero-step move on motor 0: done at offset 2, nothing moves
        offer(2'd0, 8'd0, 1'b1, 16'd4);
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("zero_done2", done, 1'b1);
        chk("zero_pos",   position, 24'h00FC03);
        tick();

        // Out-of-range motor index with non-zero steps: also a 0-step move
        offer(2'd3, 8'd5, 1'b1, 16'd1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("inv_done2", done, 1'b1);
        chk("inv_pos",   position, 24'h00FC03);
        chk("inv_phase", phase,    12'h826);
        tick();

        // cmd_valid held through a move: re-accepted only once back in IDLE
        offer(2'd2, 8'd1, 1'b1, 16'd3);
        tick();
        tick();
        chk("hold_pos1", position, 24'h01FC03);
        ticks(4);
        chk("hold_done6", done, 1'b1);
        tick();
        chk("hold_ready7", cmd_if.cmd_ready, 1'b1);
        chk("hold_pos7",   position, 24'h01FC03);
        tick();
        cmd_if.cmd_valid = 1'b0;
        chk("hold_busy_again", busy, 1'b1);
        tick();
        chk("hold_pos2", position, 24'h02FC03);
        wait_done("hold_done2nd", 2, 6);
        chk("hold_phase", phase, 12'h426);
        tick();

        // Motor 0, +10 half-steps, delay 5; abort pulsed in the 3rd DELAY
        offer(2'd0, 8'd10, 1'b1, 16'd5);
        tick();
        cmd_if.cmd_valid = 1'b0;
        ticks(14);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`ifdef MOTOR_STEP_ABORT_EN
        chk("abort_done16", done,    1'b1);
        chk("abort_flag",   aborted, 1'b1);
`else
        chk("noabort_busy16", busy, 1'b1);
        wait_done("noabort_done62", 16, 62);
        chk("noabort_flag", aborted, 1'b0);
`endif
        chk("abort_pos", position, {8'h02, 8'hFC, M0_AFTER_ABORT});
        tick();

        // Motor 1, -128 half-steps, delay 1: 252 - 128 = 124, done at offset 258
        offer(2'd1, 8'h80, 1'b1, 16'd1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        wait_done("min_done258", 1, 258);
        chk("min_pos",   position, {8'h02, 8'h7C, M0_AFTER_ABORT});
        chk("min_phase", phase,    {4'b0100, 4'b0010, PH0_AFTER});
        tick();

        // Reset asserted mid-move clears everything and yields no done
        offer(2'd0, 8'd5, 1'b1, 16'd3);
        tick();
        cmd_if.cmd_valid = 1'b0;
        ticks(3);
        reset_n = 1'b0;
        #1;
        chk("mrst_pos",   position, 24'h000000);
        chk("mrst_phase", phase,    12'h888);
        chk("mrst_busy",  busy,     1'b0);
        chk("mrst_ready", cmd_if.cmd_ready, 1'b1);
        tick();
        reset_n = 1'b1;
        ticks(20);
        chk("mrst_nodone", done, 1'b0);
        chk("mrst_pos2",   position, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/motor_step_engine.md
# motor_step_engine

Parametrised multi-motor step sequencer for the stepper-motor ASIP datapath. Accepts one move command at a time (motor index, signed step count, full/half-step mode, inter-step delay), walks the selected motor's position one step per period, and drives four winding-phase outputs per motor from an 8-entry half-step table. Replaces the single-motor MOVR/MOVRHS/PAUSE delay loops in the control FSM; the FSM issues commands and waits for `done`.

## Interface
- `NUM_MOTORS`, 2: motors driven; `MOTOR_W = (NUM_MOTORS>1) ? $clog2(NUM_MOTORS) : 1`
- `STEP_W`, 8: width of signed step count
- `DELAY_W`, 16: width of inter-step delay (clk cycles)
- `POS_W`, 8: per-motor position width, in half-step units, unsigned wrap

- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  engine can accept; high only in IDLE
- `cmd_motor`  in  MOTOR_W  target motor; values ≥ NUM_MOTORS complete as a 0-step move
- `cmd_steps`  in  STEP_W  signed step count; sign = direction
- `cmd_half`  in  1  1 = half-step (±1 position), 0 = full-step (±2)
- `cmd_delay`  in  DELAY_W  cycles in DELAY per step; 0 treated as 1
- `abort`  in  1  stop current move (ABORT_EN only)
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on move completion
- `aborted`  out  1  valid with `done`; 1 = move ended by abort
- `position`  out  NUM_MOTORS*POS_W  flattened positions, motor 0 in LSBs
- `phase`  out  NUM_MOTORS*4  flattened winding drive, motor 0 in LSBs

## Operation
- States: IDLE, CHECK, DELAY, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch motor, direction, magnitude `|cmd_steps|` (STEP_W-bit unsigned; -2^(STEP_W-1) gives 2^(STEP_W-1) steps), increment (1 or 2), delay → CHECK.
- CHECK: remaining = 0 → DONE. Otherwise position[m] ± increment (mod 2^POS_W), remaining −1, load delay counter → DELAY.
- DELAY: counter counts down; on last delay cycle → CHECK.
- DONE: `done`=1, `aborted` per cause → IDLE.
- Phase: index = position[m][2:0]; 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001 (bits A,B,A',B', MSB first). Registered from position; unselected motors hold.
- Full-step from odd position stays on odd (two-coil) entries; no realignment.
- `cmd_valid` outside IDLE ignored; no queueing.

## Timing
- Reset: state IDLE, all positions 0, all phases 1000, `busy`/`done`/`aborted` 0, `cmd_ready` 1.
- Accept at edge k (IDLE, `cmd_valid`): first CHECK in cycle k+1; position change visible k+2, phase k+2.
- Step period = 1 + D cycles (D = max(cmd_delay,1)).
- N steps: `done` high in cycle k+2+N(1+D); `cmd_ready` high cycle after `done`.
- N = 0 (or invalid motor): `done` in cycle k+2, position unchanged.
- Reset mid-move: immediate IDLE, positions cleared, no `done`.

## Configuration
- `MOTOR_STEP_ABORT_EN` defined: `abort`=1 in CHECK → DONE next, no step applied; in DELAY → DONE next, steps already applied kept; `aborted`=1 with `done`. `abort` in IDLE/DONE ignored.
- Undefined: `abort` port present but ignored; `aborted` tied 0.

## Structure
- Package `motor_step_pkg`: state encoding constants, 8-entry phase table, full/half increment constants.
- Sub-module `step_delay_counter` (load, enable, DELAY_W count, `expired` flag); engine instantiates one.

## Test plan
- Reset, no commands → positions 0, phases 1000 per motor, `cmd_ready`=1, `busy`=0.
- Motor 0, steps=+3, half, delay=2 → position 1,2,3 at 3-cycle spacing; phases 1100,0100,0110; `done` in cycle k+11.
- Motor 1, steps=-2, full, delay=0 from 0 → positions 254, 252 (wrap); phases 1001? no: index 6→0001, 4→0010; motor 0 unchanged; `done` at k+6.
- steps=0 and cmd_motor=NUM_MOTORS → `done` at k+2, no position change; `cmd_valid` held during busy accepted only after IDLE.
- With `MOTOR_STEP_ABORT_EN`: steps=+10, delay=5, `abort` pulsed during 3rd DELAY → position +3, `done`+`aborted`=1 next cycle; without macro, same stimulus completes 10 steps, `aborted`=0.
- steps=-128 (STEP_W=8), half, delay=1 → 128 decrements, position returns to start−128 mod 256; reset_n asserted mid-move clears state, no `done`.
